serial_add_sequencer: RTL and testbench

//  Bit-serial adder controller. Operands enter in parallel. One shared 1-bit adder cell is

---
 rtl/serial_add_sequencer_pkg.sv | 12 +
 rtl/serial_add_sequencer_fa_cell.sv | 20 ++
 rtl/serial_add_sequencer.sv | 124 ++++++++++++
 tb/tb_serial_add_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_add_sequencer_pkg.sv
// Shared arithmetic definitions for the serial adder: FSM encodings and default word width.
package serial_add_sequencer_pkg;

  localparam int DLD_WORD_W = 8;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_add_sequencer_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder built from two half-add stages and an OR.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g_ab;
  logic g_pc;

  assign p    = a ^ b;
  assign g_ab = a & b;
  assign s    = p ^ cin;
  assign g_pc = p & cin;
  assign cout = g_ab | g_pc;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one shared full-adder cell stepped LSB first over WIDTH cycles.
// Optional SERIAL_ADD_SUB_EN adds a SUB port selecting A-B (two's complement via ~B and carry 1).
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DLD_WORD_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
  assign b_load = SUB ? ~B : B;
  assign c_load = SUB ? 1'b1 : CIN;
`else
  assign b_load = B;
  assign c_load = CIN;
`endif

  serial_fa_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sum_d    = sum_q;
    c_d      = c_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      SA_IDLE: begin
        if (START) begin
          a_sr_d  = A;
          b_sr_d  = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = SA_RUN;
        end
      end
      SA_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        c_d      = fa_cout;
        res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        // Result registers are only touched on the last bit so SUM/COUT never show partials.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, res_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          cnt_d   = '0;
          state_d = SA_DONE;
        end
      end
      SA_DONE: begin
        state_d = SA_IDLE;
      end
      default: begin
        state_d = SA_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= SA_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sum_q    <= sum_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign BUSY = (state_q != SA_IDLE);
  assign DONE = (state_q == SA_DONE);
  assign SUM  = sum_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer: stimulus pushes hand-computed results, monitor checks DONE.
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         SUB = 1'b0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         COUT;

  int errors = 0;
  int checks = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] hold_sum = '0;
  logic         hold_cout = 1'b0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
`ifdef SERIAL_ADD_SUB_EN
    .SUB   (SUB),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .COUT  (COUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expected result.
  always @(negedge CLK) begin
    if (RST_N && DONE) begin
      logic [W:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: SUM=%0h COUT=%0b with no pending op", SUM, COUT);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({COUT, SUM} !== e) begin
          errors++;
          $display("FAIL done_result: got cout=%0b sum=%0h, expected cout=%0b sum=%0h",
                   COUT, SUM, e[W], e[W-1:0]);
        end else begin
          $display("done: sum=%0h cout=%0b", SUM, COUT);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY !== 1'b0) chk("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  // Issue one op; start_at/rst_at inject a START pulse or reset at that post-accept cycle (-1 = none).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] es, input logic ec,
                        input int start_at, input int rst_at);
    wait_idle();
    START = 1'b1; A = a; B = b; CIN = cin; SUB = sub;
    if (rst_at < 0) exp_q.push_back({ec, es});
    $display("op: a=%0h b=%0h cin=%0b sub=%0b expect sum=%0h cout=%0b", a, b, cin, sub, es, ec);
    @(negedge CLK);
    START = 1'b0; A = W'($urandom); B = W'($urandom); CIN = 1'($urandom); SUB = 1'($urandom);
    for (int i = 0; i <= W + 1; i++) begin
      if (i <= W) begin
        chk($sformatf("busy_c%0d", i), 32'(BUSY), 32'd1);
        chk($sformatf("done_c%0d", i), 32'(DONE), (i == W) ? 32'd1 : 32'd0);
      end else begin
        chk("busy_after", 32'(BUSY), 32'd0);
        chk("done_after", 32'(DONE), 32'd0);
      end
      if (i < W) begin
        chk($sformatf("sum_hold_c%0d", i), 32'(SUM), 32'(hold_sum));
        chk($sformatf("cout_hold_c%0d", i), 32'(COUT), 32'(hold_cout));
      end else begin
        chk("sum_final", 32'(SUM), 32'(es));
        chk("cout_final", 32'(COUT), 32'(ec));
      end
      if (i == rst_at) begin
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        hold_sum = '0; hold_cout = 1'b0;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_sum", 32'(SUM), 32'd0);
        chk("abort_cout", 32'(COUT), 32'd0);
        for (int j = 0; j < W + 4; j++) begin
          @(negedge CLK);
          chk("abort_no_done", 32'(DONE), 32'd0);
        end
        return;
      end
      if (i == start_at) begin
        START = 1'b1; A = 8'hAA;
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
    end
    START = 1'b0;
    hold_sum = es; hold_cout = ec;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_sum", 32'(SUM), 32'd0);
    chk("rst_cout", 32'(COUT), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    run_op(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, -1, -1);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, -1, -1);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, -1, -1);
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 3, -1);
    run_op(8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, -1, -1);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, W, -1);
    run_op(8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0, -1, 4);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, -1, -1);
    run_op(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, -1, -1);
    run_op(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, -1, -1);
`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, -1, -1);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, -1, -1);
    run_op(8'h07, 8'h05, 1'b1, 1'b0, 8'h0D, 1'b0, -1, -1);
`endif
    repeat (4) @(negedge CLK);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
